// File: rtl/dpram_responder_if.sv
// Request/response bundle between a RAM requester and the dpram_responder.
interface dpram_responder_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] w_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              init_busy;
  logic              req_dropped;
  logic              collision;

  modport master (
    output wr_en, wr_addr, w_data, rd_en, rd_addr,
    input  r_data, r_valid, init_busy, req_dropped, collision
  );

  modport slave (
    input  wr_en, wr_addr, w_data, rd_en, rd_addr,
    output r_data, r_valid, init_busy, req_dropped, collision
  );
endinterface

// File: rtl/dpram_responder.sv
// Single-clock dual-port RAM responder: one write port, one registered read port,
// post-reset initialisation sweep, write-first collision handling.
module dpram_responder #(
  parameter int unsigned      DATA_W   = 8,
  parameter int unsigned      ADDR_W   = 5,
  parameter int unsigned      DEPTH    = 32,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic               clk,
  input logic               rst,
  dpram_responder_if.slave  bus
);

  typedef enum logic [0:0] {StInit, StReady} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic              r_valid_q, r_valid_d;
  logic              dropped_q, dropped_d;
  logic              collision_q, collision_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              hit;

  // Next-state, memory write port selection and registered-output next values.
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    r_data_d    = r_data_q;
    r_valid_d   = 1'b0;
    dropped_d   = 1'b0;
    collision_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = sweep_q;
    mem_wdata   = INIT_VAL;
    hit         = 1'b0;
    unique case (state_q)
      StInit: begin
        // Sweep runs every cycle regardless of requests; requests are only flagged.
        mem_we    = 1'b1;
        sweep_d   = sweep_q + ADDR_W'(1);
        dropped_d = bus.wr_en | bus.rd_en;
        if (sweep_q == LastAddr) state_d = StReady;
      end
      StReady: begin
        mem_we    = bus.wr_en;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.w_data;
        hit       = bus.wr_en && (bus.wr_addr == bus.rd_addr);
        if (bus.rd_en) begin
          r_valid_d   = 1'b1;
          // Write-first: a same-address read returns the data being written.
          r_data_d    = hit ? bus.w_data : mem[bus.rd_addr];
          collision_d = hit;
        end
      end
      default: state_d = StInit;
    endcase
  end

  // State and registered outputs; reset restarts the sweep from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      sweep_q     <= '0;
      r_data_q    <= '0;
      r_valid_q   <= 1'b0;
      dropped_q   <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      r_data_q    <= r_data_d;
      r_valid_q   <= r_valid_d;
      dropped_q   <= dropped_d;
      collision_q <= collision_d;
    end
  end

  // Storage array; reset does not clear it, the sweep does.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.r_data      = r_data_q;
  assign bus.r_valid     = r_valid_q;
  assign bus.init_busy   = (state_q == StInit);
  assign bus.req_dropped = dropped_q;
  assign bus.collision   = collision_q;

endmodule

// File: doc/dpram_responder.md
Name: dpram_responder

Overview:
- Memory-side responder for the single-clock dual-port RAM request interface: one write port and one read port, 32 x 8 by default.
- Accepts wr_en/wr_addr/w_data and rd_en/rd_addr, and returns r_data with one cycle of latency.
- After every reset it runs a hardware initialisation sweep that writes INIT_VAL to every location.
- Handles same-address read/write collisions deterministically and flags requests dropped during initialisation.

Parameters:
DATA_W, 8, data width in bits
ADDR_W, 5, address width in bits
DEPTH, 32, number of words; must equal 2**ADDR_W
INIT_VAL, 0, value written to every word by the post-reset sweep

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
wr_en  input  1  write request
wr_addr  input  ADDR_W  write address
w_data  input  DATA_W  write data
rd_en  input  1  read request
rd_addr  input  ADDR_W  read address
r_data  output  DATA_W  read data, registered
r_valid  output  1  r_data updated by the read accepted at the previous edge
init_busy  output  1  initialisation sweep in progress; requests ignored
req_dropped  output  1  one-cycle pulse: a request arrived while init_busy=1
collision  output  1  one-cycle pulse, aligned with r_valid: the read hit the address written in the same cycle

Behaviour:
- Reset is synchronous and active-high. Clock is clk, reset is rst.
- Reset values: r_data=0, r_valid=0, init_busy=1, req_dropped=0, collision=0.
- On reset: FSM goes to INIT and the sweep counter goes to 0. Memory contents are not cleared by reset itself; the sweep clears them.
- Reset mid-operation (rst high in any state, including mid-sweep): aborts the current activity and restarts the sweep from address 0. Pending r_valid is cleared.
- State INIT:
  - Each edge with rst=0 writes INIT_VAL to address sweep_cnt, then increments sweep_cnt.
  - The edge that writes DEPTH-1 moves the FSM to READY; init_busy falls after that edge.
  - So the first request accepted is the one sampled at the (DEPTH+1)th edge after rst goes low.
  - Any wr_en or rd_en sampled in INIT is ignored: memory is untouched, r_valid stays 0, and req_dropped=1 for one cycle after that edge.
  - The sweep is never stalled by requests.
- State READY (no exit except via rst):
  - Write: wr_en=1 sampled at edge k writes w_data to mem[wr_addr] at edge k.
  - Read: rd_en=1 sampled at edge k loads r_data and sets r_valid=1 after edge k, so a monitor sees them at edge k+1. Latency is exactly 1.
  - No read: with rd_en=0, r_valid=0 after the edge and r_data holds its last value.
  - Simultaneous read and write to different addresses: both complete independently.
  - Same address (rd_en=wr_en=1, rd_addr==wr_addr): write-first. r_data=w_data, the memory is written, and collision=1 in the same cycle as r_valid.
  - Back-to-back reads every cycle: r_valid stays high, with one new word per cycle.
  - Back-to-back reads after a write: a read at edge k+1 of an address written at edge k returns the new data.
- Addresses are full range (DEPTH=2**ADDR_W), so no out-of-range case exists. Address 31 to 0 is normal addressing.
- r_data, r_valid and collision are all registered; there is no combinational path from inputs to outputs.

Test Plan:
1. Reset and initialisation:
   - Stimulus: rst high 3 cycles, then low; idle inputs.
   - Response: init_busy=1 for exactly 32 edges after release, then 0. Reads of addresses 0..31 all return 0x00 with r_valid one cycle after each rd_en.
2. Request during init:
   - Stimulus: at the 5th edge after release, wr_en=1, wr_addr=3, w_data=0xAA.
   - Response: req_dropped pulses once. After init, a read of address 3 returns 0x00.
3. Write/read latency:
   - Stimulus: write 0x5C to address 7 at edge k; rd_en with rd_addr=7 at edge k+1.
   - Response: r_data=0x5C and r_valid=1 at edge k+2; collision=0.
4. Same-address collision:
   - Stimulus: wr_en=rd_en=1, both addresses 12, w_data=0x3F.
   - Response: r_data=0x3F, r_valid=1, collision=1 next cycle. A later read of address 12 returns 0x3F.
5. Full-range streaming:
   - Stimulus: write data=addr^0xFF to addresses 0..31, then 32 consecutive reads of 0..31.
   - Response: r_valid high for 32 consecutive cycles; r_data matches addr^0xFF, including address 31 followed by 0.
6. Reset mid-stream:
   - Stimulus: assert rst for 1 cycle during the streaming reads of scenario 5.
   - Response: r_valid=0 and init_busy=1 after the reset edge; the sweep restarts. After 32 edges, all locations read 0x00.
